// File: rtl/uart_pkg.sv
// Shared types for the UART command deframer: FSM states, frame error codes, default sync marker.
package uart_pkg;

   typedef enum logic [2:0] {
      HUNT    = 3'd0,
      OPCODE  = 3'd1,
      LEN     = 3'd2,
      PAYLOAD = 3'd3,
      CHECK   = 3'd4
   } state_t;

   typedef enum logic [2:0] {
      ERR_NONE     = 3'd0,
      ERR_CHECKSUM = 3'd1,
      ERR_OVERFLOW = 3'd2,
      ERR_BAD_LEN  = 3'd3,
      ERR_TIMEOUT  = 3'd4
   } err_t;

   localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_byte_fifo.sv
// Synchronous payload FIFO. When it is full, a push in the same cycle as a pop still succeeds.
// The head is read directly from the storage array and forced to zero while the FIFO is empty.
module uart_byte_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty,
   output logic             overflow
);

   localparam int AW = $clog2(DEPTH);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_byte_fifo: DEPTH must be a power of two >= 2");
   end

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr_reg;
   logic [AW:0]      rd_ptr_reg;
   logic             push_ok;
   logic             pop_ok;

   assign empty    = (wr_ptr_reg == rd_ptr_reg);
   assign full     = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
   assign pop_ok   = pop & ~empty;
   assign push_ok  = push & (~full | pop_ok);
   assign overflow = push & ~push_ok;
   assign head     = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr_reg[AW-1:0]] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
   end

endmodule

// File: rtl/uart_cmd_deframer.sv
// Recovers SYNC/OPCODE/LEN/payload/XOR-checksum frames from the UART byte stream.
// Optional inter-byte timeout abort is enabled by defining UART_DEFRAMER_TIMEOUT_EN.
module uart_cmd_deframer
   import uart_pkg::*;
#(
   parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
   parameter int         MAX_LEN        = 64,
   parameter int         FIFO_DEPTH     = 16,
   parameter int         TIMEOUT_CYCLES = 1_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_valid,
   input  logic [7:0] rx_byte,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_data,
   output logic       out_last,
   output logic       hdr_valid,
   output logic [7:0] hdr_opcode,
   output logic [7:0] hdr_len,
   output logic       frame_done,
   output logic [2:0] err_code,
   output logic       busy
);

   if (MAX_LEN < 1 || MAX_LEN > 255 || TIMEOUT_CYCLES < 2) begin : g_bad_params
      $error("uart_cmd_deframer: MAX_LEN or TIMEOUT_CYCLES out of range");
   end

   localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

   state_t     state_reg, state_next;
   logic       rx_valid_d_reg;
   logic       acc;
   logic [7:0] opcode_reg;
   logic [7:0] chk_reg;
   logic [7:0] cnt_reg;
   logic       overflow_reg;
   logic       hdr_valid_reg;
   logic [7:0] hdr_opcode_reg;
   logic [7:0] hdr_len_reg;
   logic       frame_done_reg;
   err_t       err_code_reg;

   logic       push;
   logic       hdr_set;
   logic       done_set;
   err_t       done_err;
   logic       tmo_hit;
   logic       fifo_empty;
   logic       fifo_full;
   logic       fifo_overflow;
   logic [8:0] fifo_head;

   assign acc = rx_valid & ~rx_valid_d_reg;

`ifdef UART_DEFRAMER_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES);
   logic [TW-1:0] tmo_cnt_reg;

   always_ff @(posedge clk) begin
      if (!rst) begin
         tmo_cnt_reg <= '0;
      end else if (acc) begin
         tmo_cnt_reg <= '0;
      end else if (busy) begin
         tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
      end
   end

   // Fires on the edge where the counter reaches TIMEOUT_CYCLES-1, so frame_done lands in the same cycle.
   assign tmo_hit = busy & ~acc & (tmo_cnt_reg == TW'(TIMEOUT_CYCLES - 2));
`else
   assign tmo_hit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg <= HUNT;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      if (tmo_hit) begin
         state_next = HUNT;
      end else if (acc) begin
         case (state_reg)
            HUNT:    if (rx_byte == SYNC_BYTE) state_next = OPCODE;
            OPCODE:  state_next = LEN;
            LEN: begin
               if (rx_byte > MAX_LEN_B)    state_next = HUNT;
               else if (rx_byte == 8'd0)   state_next = CHECK;
               else                        state_next = PAYLOAD;
            end
            PAYLOAD: if (cnt_reg == 8'd1) state_next = CHECK;
            CHECK:   state_next = HUNT;
            default: state_next = HUNT;
         endcase
      end
   end

   always_comb begin
      push     = 1'b0;
      hdr_set  = 1'b0;
      done_set = 1'b0;
      done_err = ERR_NONE;
      if (tmo_hit) begin
         done_set = 1'b1;
         done_err = ERR_TIMEOUT;
      end else if (acc) begin
         case (state_reg)
            LEN: begin
               if (rx_byte > MAX_LEN_B) begin
                  done_set = 1'b1;
                  done_err = ERR_BAD_LEN;
               end else begin
                  hdr_set = 1'b1;
               end
            end
            PAYLOAD: push = 1'b1;
            CHECK: begin
               done_set = 1'b1;
               if (overflow_reg)            done_err = ERR_OVERFLOW;
               else if (rx_byte != chk_reg) done_err = ERR_CHECKSUM;
               else                         done_err = ERR_NONE;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         rx_valid_d_reg <= 1'b0;
         opcode_reg     <= '0;
         chk_reg        <= '0;
         cnt_reg        <= '0;
         overflow_reg   <= 1'b0;
         hdr_valid_reg  <= 1'b0;
         hdr_opcode_reg <= '0;
         hdr_len_reg    <= '0;
         frame_done_reg <= 1'b0;
         err_code_reg   <= ERR_NONE;
      end else begin
         rx_valid_d_reg <= rx_valid;
         hdr_valid_reg  <= hdr_set;
         frame_done_reg <= done_set;
         if (hdr_set) begin
            hdr_opcode_reg <= opcode_reg;
            hdr_len_reg    <= rx_byte;
         end
         if (done_set) err_code_reg <= done_err;
         if (acc) begin
            case (state_reg)
               OPCODE: begin
                  opcode_reg   <= rx_byte;
                  chk_reg      <= rx_byte;
                  overflow_reg <= 1'b0;
               end
               LEN: begin
                  chk_reg <= chk_reg ^ rx_byte;
                  cnt_reg <= rx_byte;
               end
               PAYLOAD: begin
                  chk_reg <= chk_reg ^ rx_byte;
                  cnt_reg <= cnt_reg - 8'd1;
                  if (fifo_overflow) overflow_reg <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   uart_byte_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (9)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data ({(cnt_reg == 8'd1), rx_byte}),
      .pop       (out_ready),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .overflow  (fifo_overflow)
   );

   assign out_valid  = ~fifo_empty;
   assign out_data   = fifo_head[7:0];
   assign out_last   = fifo_head[8];
   assign hdr_valid  = hdr_valid_reg;
   assign hdr_opcode = hdr_opcode_reg;
   assign hdr_len    = hdr_len_reg;
   assign frame_done = frame_done_reg;
   assign err_code   = err_code_reg;
   assign busy       = (state_reg != HUNT);

   // fifo_full is consumed inside the FIFO's own push rule; kept visible here for debug probing.
   logic unused_full;
   assign unused_full = fifo_full;

endmodule

// File: tb/tb_uart_cmd_deframer.sv
// Directed bench for uart_cmd_deframer; add +define+UART_DEFRAMER_TIMEOUT_EN to exercise the timeout path.
module tb_uart_cmd_deframer;

   typedef logic [7:0] bq_t[$];

`ifdef UART_DEFRAMER_TIMEOUT_EN
   localparam int HOLD_LONG = 60;
`else
   localparam int HOLD_LONG = 200;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       rx_valid;
   logic [7:0] rx_byte;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic       out_last;
   logic       hdr_valid;
   logic [7:0] hdr_opcode;
   logic [7:0] hdr_len;
   logic       frame_done;
   logic [2:0] err_code;
   logic       busy;

   int errors = 0;
   int checks = 0;
   int hdr_cnt = 0;
   int done_cnt = 0;
   logic [8:0] popq[$];
   int h0, d0, q0;
   bq_t seq;

   always #5 clk = ~clk;

   uart_cmd_deframer #(
      .TIMEOUT_CYCLES (100)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .rx_valid   (rx_valid),
      .rx_byte    (rx_byte),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_last   (out_last),
      .hdr_valid  (hdr_valid),
      .hdr_opcode (hdr_opcode),
      .hdr_len    (hdr_len),
      .frame_done (frame_done),
      .err_code   (err_code),
      .busy       (busy)
   );

   always @(negedge clk) begin
      if (hdr_valid)  hdr_cnt++;
      if (frame_done) done_cnt++;
      if (out_valid && out_ready) popq.push_back({out_last, out_data});
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [8:0] q_at(input int i);
      return (i < popq.size()) ? popq[i] : 9'bx;
   endfunction

   task automatic snap();
      h0 = hdr_cnt;
      d0 = done_cnt;
      q0 = popq.size();
   endtask

   task automatic send_byte(input logic [7:0] b, input int hold);
      @(posedge clk); #1;
      rx_byte  = b;
      rx_valid = 1'b1;
      repeat (hold) @(posedge clk);
      #1 rx_valid = 1'b0;
      repeat (2) @(posedge clk);
   endtask

   task automatic send_seq(input bq_t s);
      foreach (s[i]) send_byte(s[i], 4);
      repeat (3) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_frame(input string tag, input int hdrs, input logic [7:0] op,
                              input logic [7:0] len, input int pops, input int dones,
                              input logic [2:0] err);
      check({tag, "_hdrs"}, hdr_cnt - h0, hdrs);
      check({tag, "_op"}, hdr_opcode, op);
      check({tag, "_len"}, hdr_len, len);
      check({tag, "_pops"}, popq.size() - q0, pops);
      check({tag, "_dones"}, done_cnt - d0, dones);
      check({tag, "_err"}, err_code, err);
      check({tag, "_busy"}, busy, 1'b0);
      $display("txn %s: op=%0h len=%0h pops=%0d err=%0d", tag, hdr_opcode, hdr_len,
               popq.size() - q0, err_code);
   endtask

   initial begin
      int cyc;
      rst = 1'b0; rx_valid = 1'b0; rx_byte = 8'h00; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_hdr_valid", hdr_valid, 1'b0);
      check("rst_frame_done", frame_done, 1'b0);
      check("rst_err", err_code, 3'd0);
      check("rst_out_data", out_data, 8'h00);
      check("rst_out_last", out_last, 1'b0);
      @(posedge clk); #1 rst = 1'b1;

      // good frame
      snap();
      seq = '{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h21};
      send_seq(seq);
      check_frame("good", 1, 8'h10, 8'h02, 2, 1, 3'd0);
      check("good_b0", q_at(q0), 9'h011);
      check("good_b1", q_at(q0 + 1), 9'h122);

      // bad checksum: payload still streamed
      snap();
      seq = '{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h20};
      send_seq(seq);
      check_frame("badchk", 1, 8'h10, 8'h02, 2, 1, 3'd1);
      check("badchk_b1", q_at(q0 + 1), 9'h122);

      // noise then zero-length frame
      snap();
      seq = '{8'h00, 8'hFF, 8'hA5, 8'h33, 8'h00, 8'h33};
      send_seq(seq);
      check_frame("len0", 1, 8'h33, 8'h00, 0, 1, 3'd0);

      // length above MAX_LEN: no header, header outputs keep last frame
      snap();
      seq = '{8'hA5, 8'h10, 8'h50};
      send_seq(seq);
      check_frame("badlen", 0, 8'h33, 8'h00, 0, 1, 3'd3);
      send_byte(8'h10, 4);
      @(negedge clk);
      check("badlen_hunt", busy, 1'b0);

      // acc -> out_valid latency with empty FIFO
      snap();
      seq = '{8'hA5, 8'h20, 8'h01};
      send_seq(seq);
      @(posedge clk); #1;
      rx_byte = 8'h5A; rx_valid = 1'b1;
      @(negedge clk);
      check("lat_acc_cycle", out_valid, 1'b0);
      @(negedge clk);
      check("lat_next_cycle", out_valid, 1'b1);
      repeat (3) @(posedge clk);
      #1 rx_valid = 1'b0;
      seq = '{8'h7B};
      send_seq(seq);
      check_frame("lat", 1, 8'h20, 8'h01, 1, 1, 3'd0);
      check("lat_b0", q_at(q0), 9'h15A);

      // overflow: 20 payload bytes into a 16-deep FIFO with consumer stalled
      out_ready = 1'b0;
      snap();
      seq = '{8'hA5, 8'h40, 8'h14};
      for (int i = 1; i <= 20; i++) seq.push_back(8'(i));
      seq.push_back(8'h40);
      send_seq(seq);
      check_frame("ovf", 1, 8'h40, 8'h14, 0, 1, 3'd2);
      check("ovf_held", out_valid, 1'b1);
      @(posedge clk); #1 out_ready = 1'b1;
      repeat (20) @(posedge clk);
      @(negedge clk);
      check("ovf_pops", popq.size() - q0, 16);
      check("ovf_first", q_at(q0), 9'h001);
      check("ovf_sixteenth", q_at(q0 + 15), 9'h010);
      check("ovf_drained", out_valid, 1'b0);

      // reset in the middle of a frame with bytes held
      @(posedge clk); #1 out_ready = 1'b0;
      snap();
      seq = '{8'hA5, 8'h41, 8'h03, 8'h01, 8'h02};
      send_seq(seq);
      check("mid_held", out_valid, 1'b1);
      check("mid_busy", busy, 1'b1);
      @(posedge clk); #1 rst = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("mid_rst_valid", out_valid, 1'b0);
      check("mid_rst_busy", busy, 1'b0);
      @(posedge clk); #1 rst = 1'b1; out_ready = 1'b1;
      repeat (5) @(posedge clk);
      @(negedge clk);
      check("mid_rst_nodone", done_cnt - d0, 0);
      check("mid_rst_nopop", popq.size() - q0, 0);
      $display("txn midrst: fifo flushed, busy=%0d", busy);

      // long rx_valid level yields one acceptance only
      snap();
      send_byte(8'hA5, 4);
      send_byte(8'h77, HOLD_LONG);
      seq = '{8'h00, 8'h77};
      send_seq(seq);
      check_frame("hold", 1, 8'h77, 8'h00, 0, 1, 3'd0);

`ifdef UART_DEFRAMER_TIMEOUT_EN
      snap();
      send_byte(8'hA5, 4);
      @(posedge clk); #1;
      rx_byte = 8'h10; rx_valid = 1'b1;
      cyc = 0;
      while (cyc < 400) begin
         @(posedge clk);
         cyc++;
         if (cyc == 4) #1 rx_valid = 1'b0;
         @(negedge clk);
         if (frame_done) break;
      end
      check("tmo_cycles", cyc, 100);
      check("tmo_err", err_code, 3'd4);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("tmo_busy", busy, 1'b0);
      check("tmo_dones", done_cnt - d0, 1);
      $display("txn timeout: cycles=%0d err=%0d", cyc, err_code);
`else
      snap();
      seq = '{8'hA5, 8'h10};
      send_seq(seq);
      cyc = 150;
      repeat (cyc) @(posedge clk);
      @(negedge clk);
      check("stall_busy", busy, 1'b1);
      check("stall_nodone", done_cnt - d0, 0);
      seq = '{8'h00, 8'h10};
      send_seq(seq);
      check_frame("stall", 1, 8'h10, 8'h00, 0, 1, 3'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
